// File: rtl/gfx_project.sv
`default_nettype none
// ============================================================================
// Module   : gfx_project
// Purpose  : Perspective projection of one transformed point:
//            x_s = x*focal/z + cx, y_s = y*focal/z + cy.
//            Both quotients come from restoring dividers that share the
//            divisor |z| and produce one bit per clock.
//            Optional macro GFX_PROJECT_ZCLIP_EN also rejects z < 0.
// Revision : 1.0 - initial release
// ============================================================================
module gfx_project #(
   parameter int POINT_WIDTH    = 16,
   parameter int SUBPIXEL_WIDTH = 16
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic                                  start_i,
   input  logic [1:0]                            point_id_i,
   input  logic [POINT_WIDTH+SUBPIXEL_WIDTH-1:0] p0_x_i,
   input  logic [POINT_WIDTH+SUBPIXEL_WIDTH-1:0] p0_y_i,
   input  logic [POINT_WIDTH-1:0]                p0_z_i,
   input  logic [POINT_WIDTH+SUBPIXEL_WIDTH-1:0] p1_x_i,
   input  logic [POINT_WIDTH+SUBPIXEL_WIDTH-1:0] p1_y_i,
   input  logic [POINT_WIDTH-1:0]                p1_z_i,
   input  logic [POINT_WIDTH+SUBPIXEL_WIDTH-1:0] p2_x_i,
   input  logic [POINT_WIDTH+SUBPIXEL_WIDTH-1:0] p2_y_i,
   input  logic [POINT_WIDTH-1:0]                p2_z_i,
   input  logic [POINT_WIDTH+SUBPIXEL_WIDTH-1:0] focal_i,
   input  logic [POINT_WIDTH+SUBPIXEL_WIDTH-1:0] cx_i,
   input  logic [POINT_WIDTH+SUBPIXEL_WIDTH-1:0] cy_i,
   output logic                                  busy_o,
   output logic                                  ack_o,
   output logic                                  div_err_o,
   output logic [POINT_WIDTH+SUBPIXEL_WIDTH-1:0] x_o,
   output logic [POINT_WIDTH+SUBPIXEL_WIDTH-1:0] y_o,
   output logic [POINT_WIDTH-1:0]                z_o
);

   localparam int PW = POINT_WIDTH;
   localparam int FW = POINT_WIDTH + SUBPIXEL_WIDTH;
   localparam int NW = 2 * POINT_WIDTH + SUBPIXEL_WIDTH;
   localparam int CW = $clog2(NW);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

   state_t               state_q, state_d;
   logic signed [FW-1:0] x_l_q, y_l_q, focal_q, cx_q, cy_q;
   logic signed [PW-1:0] z_l_q;
   logic [1:0]           id_q;
   logic                 rej_q, sx_q, sy_q;
   logic [NW-1:0]        numx_q, numy_q;   // numerator magnitude, shifts out as quotient shifts in
   logic [PW-1:0]        remx_q, remy_q, div_q;
   logic [CW-1:0]        cnt_q;
   logic                 busy_q, ack_q, err_q;
   logic [FW-1:0]        x_q, y_q;
   logic [PW-1:0]        z_q;

   logic [FW-1:0]        w_sel_x, w_sel_y;
   logic [PW-1:0]        w_sel_z;
   logic                 w_rej;
   logic signed [2*FW-1:0] w_prod_x, w_prod_y;
   logic signed [NW-1:0] w_nx, w_ny;
   logic [NW-1:0]        w_nx_mag, w_ny_mag;
   logic [PW-1:0]        w_z_mag;
   logic [PW:0]          w_remx_sh, w_remy_sh;
   logic                 w_gex, w_gey;
   logic [PW-1:0]        w_remx_nx, w_remy_nx;
   logic signed [NW:0]   w_qx_s, w_qy_s, w_sumx, w_sumy;

   // Clamp an NW+1-bit signed sum into the FW-bit signed output range.
   function automatic logic [FW-1:0] sat(input logic signed [NW:0] v);
      if ((v[NW:FW-1] == '0) || (v[NW:FW-1] == '1)) return v[FW-1:0];
      else if (v[NW]) return {1'b1, {(FW-1){1'b0}}};
      else return {1'b0, {(FW-1){1'b1}}};
   endfunction

   // Input point selection; id 3 reads p0 but is rejected later.
   always_comb begin
      w_sel_x = p0_x_i;
      w_sel_y = p0_y_i;
      w_sel_z = p0_z_i;
      case (point_id_i)
         2'd1: begin w_sel_x = p1_x_i; w_sel_y = p1_y_i; w_sel_z = p1_z_i; end
         2'd2: begin w_sel_x = p2_x_i; w_sel_y = p2_y_i; w_sel_z = p2_z_i; end
         default: ;
      endcase
   end

`ifdef GFX_PROJECT_ZCLIP_EN
   assign w_rej = (id_q == 2'd3) || z_l_q[PW-1] || (z_l_q == '0);
`else
   assign w_rej = (id_q == 2'd3) || (z_l_q == '0);
`endif

   // Scaled numerators: (v*focal) >>> subpixel bits, then magnitudes for the divider.
   assign w_prod_x = (2*FW)'(x_l_q) * (2*FW)'(focal_q);
   assign w_prod_y = (2*FW)'(y_l_q) * (2*FW)'(focal_q);
   assign w_nx     = NW'(w_prod_x >>> SUBPIXEL_WIDTH);
   assign w_ny     = NW'(w_prod_y >>> SUBPIXEL_WIDTH);
   assign w_nx_mag = w_nx[NW-1] ? NW'(-w_nx) : NW'(w_nx);
   assign w_ny_mag = w_ny[NW-1] ? NW'(-w_ny) : NW'(w_ny);
   assign w_z_mag  = z_l_q[PW-1] ? PW'(-z_l_q) : PW'(z_l_q);

   // One restoring step per lane; the remainder stays below |z| so PW bits suffice.
   assign w_remx_sh = {remx_q, numx_q[NW-1]};
   assign w_remy_sh = {remy_q, numy_q[NW-1]};
   assign w_gex     = (w_remx_sh >= {1'b0, div_q});
   assign w_gey     = (w_remy_sh >= {1'b0, div_q});
   assign w_remx_nx = w_gex ? PW'(w_remx_sh - {1'b0, div_q}) : PW'(w_remx_sh);
   assign w_remy_nx = w_gey ? PW'(w_remy_sh - {1'b0, div_q}) : PW'(w_remy_sh);

   // Signed quotient (truncated toward zero) plus screen centre.
   assign w_qx_s = sx_q ? -$signed({1'b0, numx_q}) : $signed({1'b0, numx_q});
   assign w_qy_s = sy_q ? -$signed({1'b0, numy_q}) : $signed({1'b0, numy_q});
   assign w_sumx = w_qx_s + (NW+1)'(cx_q);
   assign w_sumy = w_qy_s + (NW+1)'(cy_q);

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Next state; a rejected request still passes through FIX so its ack lands two edges after start.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_i) state_d = S_MUL;
         S_MUL:   state_d = w_rej ? S_FIX : S_DIV;
         S_DIV:   if (cnt_q == CW'(NW-1)) state_d = S_FIX;
         S_FIX:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath: operand capture, numerator setup, serial divide, result write-back.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         x_l_q <= '0; y_l_q <= '0; z_l_q <= '0; focal_q <= '0; cx_q <= '0; cy_q <= '0;
         id_q <= '0; rej_q <= 1'b0; sx_q <= 1'b0; sy_q <= 1'b0;
         numx_q <= '0; numy_q <= '0; remx_q <= '0; remy_q <= '0; div_q <= '0; cnt_q <= '0;
         x_q <= '0; y_q <= '0; z_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (start_i) begin
               x_l_q <= w_sel_x; y_l_q <= w_sel_y; z_l_q <= w_sel_z;
               focal_q <= focal_i; cx_q <= cx_i; cy_q <= cy_i; id_q <= point_id_i;
            end
            S_MUL: begin
               rej_q  <= w_rej;
               numx_q <= w_nx_mag;
               numy_q <= w_ny_mag;
               remx_q <= '0;
               remy_q <= '0;
               div_q  <= w_z_mag;
               sx_q   <= w_nx[NW-1] ^ z_l_q[PW-1];
               sy_q   <= w_ny[NW-1] ^ z_l_q[PW-1];
               cnt_q  <= '0;
            end
            S_DIV: begin
               numx_q <= {numx_q[NW-2:0], w_gex};
               numy_q <= {numy_q[NW-2:0], w_gey};
               remx_q <= w_remx_nx;
               remy_q <= w_remy_nx;
               cnt_q  <= cnt_q + 1'b1;
            end
            S_FIX: if (!rej_q) begin
               x_q <= sat(w_sumx);
               y_q <= sat(w_sumy);
               z_q <= z_l_q;
            end
            default: ;
         endcase
      end
   end

   // Registered handshake outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q <= 1'b0; ack_q <= 1'b0; err_q <= 1'b0;
      end else begin
         busy_q <= (state_d != S_IDLE);
         ack_q  <= (state_q == S_FIX);
         err_q  <= (state_q == S_FIX) && rej_q;
      end
   end

   assign busy_o    = busy_q;
   assign ack_o     = ack_q;
   assign div_err_o = err_q;
   assign x_o       = x_q;
   assign y_o       = y_q;
   assign z_o       = z_q;

endmodule
`default_nettype wire

// File: tb/tb_gfx_project.sv
`default_nettype none
// ============================================================================
// Module   : tb_gfx_project
// Purpose  : Scoreboard bench for gfx_project with a reference projection
//            model written in plain 64-bit arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gfx_project;

   logic        clk = 1'b0;
   logic        rst_n, start;
   logic [1:0]  id;
   logic [31:0] px [3];
   logic [31:0] py [3];
   logic [15:0] pz [3];
   logic [31:0] focal, cx, cy;
   logic        busy, ack, err;
   logic [31:0] x_o, y_o;
   logic [15:0] z_o;

   gfx_project dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .point_id_i(id),
      .p0_x_i(px[0]), .p0_y_i(py[0]), .p0_z_i(pz[0]),
      .p1_x_i(px[1]), .p1_y_i(py[1]), .p1_z_i(pz[1]),
      .p2_x_i(px[2]), .p2_y_i(py[2]), .p2_z_i(pz[2]),
      .focal_i(focal), .cx_i(cx), .cy_i(cy),
      .busy_o(busy), .ack_o(ack), .div_err_o(err),
      .x_o(x_o), .y_o(y_o), .z_o(z_o)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic        err;
      logic [31:0] x;
      logic [31:0] y;
      logic [15:0] z;
      int unsigned cyc;
   } exp_t;

   exp_t sb[$];
   logic [31:0] m_x = '0, m_y = '0;
   logic [15:0] m_z = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // v*focal/z + c with truncating division and clamping to 32-bit signed.
   function automatic logic [31:0] proj(input logic signed [31:0] v, input logic signed [31:0] f,
                                        input logic signed [31:0] c, input logic signed [15:0] z);
      longint n, q, s;
      n = (longint'(v) * longint'(f)) >>> 16;
      q = n / longint'(z);
      s = q + longint'(c);
      if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
      if (s < -64'sd2147483648) return 32'h8000_0000;
      return s[31:0];
   endfunction

   // Monitor: every ack must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && ack) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("ack_cycle", 64'(cyc), 64'(e.cyc));
            chk("div_err", 64'(err), 64'(e.err));
            chk("x_out", 64'(x_o), 64'(e.x));
            chk("y_out", 64'(y_o), 64'(e.y));
            chk("z_out", 64'(z_o), 64'(e.z));
            chk("busy_at_ack", 64'(busy), 64'd0);
         end
      end
   end

   task automatic issue(input logic [1:0] i);
      int n;
      exp_t e;
      logic signed [15:0] zz;
      logic rej;
      n = 0;
      @(negedge clk);
      while (busy && n < 300) begin @(negedge clk); n++; end
      if (busy) begin
         checks++; failures++;
         $display("FAIL idle_wait: got busy=1 expected 0");
         return;
      end
      zz  = (i == 2'd3) ? 16'sd0 : pz[i];
      rej = (i == 2'd3) || (zz == 16'sd0);
`ifdef GFX_PROJECT_ZCLIP_EN
      rej = rej || (zz < 16'sd0);
`endif
      if (!rej) begin
         m_x = proj(px[i], focal, cx, zz);
         m_y = proj(py[i], focal, cy, zz);
         m_z = zz;
      end
      e.err = rej;
      e.x   = m_x;
      e.y   = m_y;
      e.z   = m_z;
      e.cyc = cyc + 1 + (rej ? 2 : 50);
      sb.push_back(e);
      id    = i;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", 64'(busy), 64'd1);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
      if (sb.size() != 0) begin
         checks++; failures++;
         $display("FAIL ack_timeout: got %0d pending expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic set_t1();
      px[0] = 32'h000A_0000; py[0] = 32'hFFFC_0000; pz[0] = 16'd2;
      focal = 32'h0001_0000; cx = 32'h0140_0000; cy = 32'h00F0_0000;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; id = '0;
      for (int k = 0; k < 3; k++) begin px[k] = '0; py[k] = '0; pz[k] = '0; end
      focal = '0; cx = '0; cy = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ack", 64'(ack), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_x", 64'(x_o), 64'd0);
      chk("rst_y", 64'(y_o), 64'd0);
      chk("rst_z", 64'(z_o), 64'd0);
      rst_n = 1'b1;

      // Basic projection.
      set_t1();
      issue(2'd0); wait_done();
      chk("t1_x", 64'(x_o), 64'h0145_0000);
      chk("t1_y", 64'(y_o), 64'h00EE_0000);

      // Positive saturation.
      px[1] = 32'h7FFF_0000; py[1] = '0; pz[1] = 16'd1;
      focal = 32'h0002_0000; cx = '0; cy = '0;
      issue(2'd1); wait_done();
      chk("t2_x", 64'(x_o), 64'h7FFF_FFFF);

      // Rejections: zero depth and invalid id keep previous results.
      pz[2] = '0; px[2] = 32'h0001_0000;
      issue(2'd2); wait_done();
      issue(2'd3); wait_done();
      chk("t3_x_held", 64'(x_o), 64'h7FFF_FFFF);

      // Negative depth.
      set_t1(); pz[0] = 16'hFFFE;
      issue(2'd0); wait_done();
`ifndef GFX_PROJECT_ZCLIP_EN
      chk("t4_x", 64'(x_o), 64'h013B_0000);
      chk("t4_y", 64'(y_o), 64'h00F2_0000);
`endif

      // Reset during the divide aborts without an ack.
      set_t1();
      issue(2'd0);
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t5_busy", 64'(busy), 64'd0);
      chk("t5_ack", 64'(ack), 64'd0);
      chk("t5_x", 64'(x_o), 64'd0);
      chk("t5_y", 64'(y_o), 64'd0);
      chk("t5_z", 64'(z_o), 64'd0);
      sb.delete();
      m_x = '0; m_y = '0; m_z = '0;
      repeat (60) @(negedge clk);
      rst_n = 1'b1;
      issue(2'd0); wait_done();

      // Start re-pulsed while busy is ignored.
      px[1] = 32'h0123_4567; pz[1] = 16'd7;
      issue(2'd0);
      @(negedge clk);
      id = 2'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      repeat (60) @(negedge clk);

      // Randomized traffic.
      for (int t = 0; t < 40; t++) begin
         for (int k = 0; k < 3; k++) begin
            px[k] = $urandom;
            py[k] = (t % 2 == 0) ? $urandom : 32'($signed($urandom_range(0, 32'h0400_0000)) - 32'sh0200_0000);
            case ($urandom_range(0, 3))
               0:       pz[k] = 16'($signed($urandom_range(0, 6)) - 3);
               1:       pz[k] = 16'($urandom);
               default: pz[k] = 16'($urandom_range(1, 4000));
            endcase
         end
         focal = (t % 3 == 0) ? $urandom : 32'($urandom_range(0, 32'h0004_0000));
         cx    = $urandom;
         cy    = 32'($urandom_range(0, 32'h0200_0000));
         issue(2'($urandom_range(0, 3)));
         wait_done();
      end

      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
